// File: rtl/seg7_debug_display_pkg.sv
// Shared constants for the seven-segment debug display: source-select codes
// and the active-low hex glyph table ({g,f,e,d,c,b,a}).
package seg7_debug_display_pkg;

    localparam logic [1:0] SRC_PC   = 2'd0;
    localparam logic [1:0] SRC_INST = 2'd1;
    localparam logic [1:0] SRC_R    = 2'd2;
    localparam logic [1:0] SRC_DOUT = 2'd3;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_debug_display_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse coincident with the accepted rising level.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic Clk,
    input  logic Clrn,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;
    logic          accept;

    // Accept fires on the cycle the counter has seen DB_CYCLES differing samples.
    assign accept = (sync_2 != level) && (cnt == CW'(DB_CYCLES - 1));
    assign rise   = accept && sync_2;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_debug_display.sv
// Multiplexed 8-digit hex display of one CPU debug word; button cycles the
// source, Freeze holds the snapshot while scanning continues.
module seg7_debug_display
    import seg7_debug_display_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic [31:0] PC,
    input  logic [31:0] Inst,
    input  logic [31:0] R,
    input  logic [31:0] Date_out,
    input  logic        Btn,
    input  logic        Freeze,
    output logic [1:0]  Src,
    output logic [7:0]  An,
    output logic [7:0]  Seg
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pre;
    logic          tick;
    logic [2:0]    digit;
    logic [1:0]    src;
    logic          src_chg;
    logic [31:0]   disp_val;
    logic [31:0]   sel_word;
    logic [3:0]    nib;
    logic          load;
    logic          btn_level;
    logic          btn_rise;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn (
        .Clk  (Clk),
        .Clrn (Clrn),
        .raw  (Btn),
        .level(btn_level),
        .rise (btn_rise)
    );

    assign tick = (pre == PW'(SCAN_DIV - 1));
    assign nib  = disp_val[{digit, 2'b00} +: 4];

    always_comb begin
        sel_word = PC;
        case (src)
            SRC_PC:   sel_word = PC;
            SRC_INST: sel_word = Inst;
            SRC_R:    sel_word = R;
            SRC_DOUT: sel_word = Date_out;
            default:  sel_word = PC;
        endcase
    end

    // Snapshot at frame boundary, or one cycle after a source change so the
    // new source shows without waiting a whole frame.
    assign load = !Freeze && ((tick && (digit == 3'd7)) || src_chg);

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pre      <= '0;
            digit    <= '0;
            src      <= SRC_PC;
            src_chg  <= 1'b0;
            disp_val <= '0;
            An       <= 8'hFF;
            Seg      <= 8'hFF;
        end else begin
            pre     <= tick ? '0 : pre + 1'b1;
            src_chg <= btn_rise;
            if (tick)
                digit <= digit + 1'b1;
            if (btn_rise)
                src <= src + 1'b1;
            if (load)
                disp_val <= sel_word;
            An  <= ~(8'b1 << digit);
            Seg <= {({1'b0, src} != digit), SEG_TABLE[nib]};
        end
    end

    assign Src = src;

endmodule

// File: tb/tb_seg7_debug_display.sv
// Directed bench for seg7_debug_display with a small expected-value queue.
module tb_seg7_debug_display;

    logic        Clk = 1'b0;
    logic        Clrn = 1'b0;
    logic [31:0] PC = '0, Inst = '0, R = '0, Date_out = '0;
    logic        Btn = 1'b0, Freeze = 1'b0;
    logic [1:0]  Src;
    logic [7:0]  An, Seg;

    int tests = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } item_t;
    item_t sb[$];

    logic [6:0] glyph [16];
    logic [1:0] exp_src;

    seg7_debug_display #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
        .Clk(Clk), .Clrn(Clrn), .PC(PC), .Inst(Inst), .R(R), .Date_out(Date_out),
        .Btn(Btn), .Freeze(Freeze), .Src(Src), .An(An), .Seg(Seg)
    );

    always #5 Clk = ~Clk;

    task automatic push(input string tag, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        item_t it;
        it = sb.pop_front();
        tests++;
        assert (obs === it.exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", it.tag, obs, it.exp);
        end
    endtask

    task automatic wait_an(input logic [7:0] target);
        int n;
        n = 0;
        while (An !== target && n < 300) begin
            @(negedge Clk);
            n++;
        end
        tests++;
        assert (An === target) else begin
            errors++;
            $error("FAIL wait_an: got %h expected %h", An, target);
        end
    endtask

    // Wait into digit 6 first so the next digit-0 slot follows a fresh boundary.
    task automatic wait_frame_digit0();
        wait_an(8'hBF);
        wait_an(8'h7F);
        wait_an(8'hFE);
    endtask

    task automatic press();
        Btn = 1'b1;
        repeat (14) @(negedge Clk);
        Btn = 1'b0;
        repeat (14) @(negedge Clk);
        exp_src = exp_src + 2'd1;
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] v, input logic dp_lit);
        return {~dp_lit, glyph[v]};
    endfunction

    initial begin
        int n;
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        exp_src = 2'd0;
        PC   = 32'h0000_0004;
        Inst = 32'hDEAD_BEEF;
        R    = 32'h0000_0001;
        Date_out = 32'h1234_5678;

        // Reset state
        repeat (3) @(negedge Clk);
        push("reset_an", 32'hFF);   pop_check({24'h0, An});
        push("reset_seg", 32'hFF);  pop_check({24'h0, Seg});
        push("reset_src", 32'h0);   pop_check({30'h0, Src});

        // First cycle after release: digit 0, value 0, dp lit
        Clrn = 1'b1;
        @(negedge Clk);
        push("first_an", 32'hFE);   pop_check({24'h0, An});
        push("first_seg", {24'h0, seg_of(4'h0, 1'b1)}); pop_check({24'h0, Seg});

        // After first frame boundary PC=4 is shown
        wait_frame_digit0();
        push("pc_d0", {24'h0, seg_of(4'h4, 1'b1)}); pop_check({24'h0, Seg});
        wait_an(8'hFD);
        push("pc_d1", {24'h0, seg_of(4'h0, 1'b0)}); pop_check({24'h0, Seg});

        // Debounced press: latency DB_CYCLES+2
        Btn = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Src === 2'd0 && n < 40);
        push("btn_latency", 32'd10); pop_check(n);
        repeat (20 - n) @(negedge Clk);
        Btn = 1'b0;
        exp_src = 2'd1;
        repeat (20) @(negedge Clk);
        push("btn_once", {30'h0, exp_src}); pop_check({30'h0, Src});

        // Inst loaded right after the source change
        wait_an(8'hBF);
        wait_an(8'h7F);
        push("inst_d7", {24'h0, seg_of(4'hD, 1'b0)}); pop_check({24'h0, Seg});
        wait_an(8'hFE);
        push("inst_d0", {24'h0, seg_of(4'hF, 1'b0)}); pop_check({24'h0, Seg});
        wait_an(8'hFD);
        push("inst_d1_dp", {24'h0, seg_of(4'hE, 1'b1)}); pop_check({24'h0, Seg});

        // Glitchy button must be ignored
        for (int g = 0; g < 3; g++) begin
            Btn = 1'b1;
            repeat (5) @(negedge Clk);
            Btn = 1'b0;
            repeat (5) @(negedge Clk);
        end
        repeat (20) @(negedge Clk);
        push("glitch", {30'h0, exp_src}); pop_check({30'h0, Src});

        // Four clean presses wrap through all sources
        for (int p = 0; p < 4; p++) begin
            press();
            push("press_src", {30'h0, exp_src}); pop_check({30'h0, Src});
            wait_an(~(8'b1 << exp_src));
            push("dp_on", 32'h0); pop_check({31'h0, Seg[7]});
            wait_an(~(8'b1 << (exp_src + 3'd1)));
            push("dp_off", 32'h1); pop_check({31'h0, Seg[7]});
        end

        // Freeze holds R=1 while R changes to 2
        press();
        push("src_r", {30'h0, exp_src}); pop_check({30'h0, Src});
        Freeze = 1'b1;
        R = 32'h0000_0002;
        for (int f = 0; f < 3; f++) begin
            wait_frame_digit0();
            push("frozen_d0", {24'h0, seg_of(4'h1, 1'b0)}); pop_check({24'h0, Seg});
        end
        Freeze = 1'b0;
        wait_frame_digit0();
        push("thawed_d0", {24'h0, seg_of(4'h2, 1'b0)}); pop_check({24'h0, Seg});

        // Asynchronous reset mid-frame
        wait_an(8'hDF);
        #1 Clrn = 1'b0;
        #1;
        push("arst_an", 32'hFF);  pop_check({24'h0, An});
        push("arst_seg", 32'hFF); pop_check({24'h0, Seg});
        push("arst_src", 32'h0);  pop_check({30'h0, Src});
        @(negedge Clk);
        Clrn = 1'b1;
        @(negedge Clk);
        push("rel_an", 32'hFE);   pop_check({24'h0, An});
        push("rel_seg", {24'h0, seg_of(4'h0, 1'b1)}); pop_check({24'h0, Seg});

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
